i2c_xfer_ctrl: RTL and testbench
================================

I2C_XFER_CTRL -- requirements
Module: i2c_xfer_ctrl

Interface
REQ-001 The module SHALL have parameter DIVIDER, default 250, giving the number of clk cycles per quarter bit-period.
REQ-002 The module SHALL have parameter CBITS, default 10, giving the width of the quarter counter; it must satisfy 2^CBITS > DIVIDER.
REQ-003 The module SHALL have port clk, input, 1 bit: clock; all logic is rising-edge triggered.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The module SHALL have port req, input, 1 bit: transfer request.
REQ-006 The module SHALL have port addr, input, 7 bits: slave address, sampled at acceptance.
REQ-007 The module SHALL have port wdata, input, 8 bits: write byte, sampled at acceptance.
REQ-008 The module SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle pulse at transfer end.
REQ-010 The module SHALL have port nack, output, 1 bit: status of the last transfer, valid from the done pulse until the next acceptance.
REQ-011 The module SHALL have port scl_oe, output, 1 bit: 1 pulls SCL low, 0 releases it.
REQ-012 The module SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low, 0 releases it.
REQ-013 The module SHALL have port scl_i, input, 1 bit: sensed SCL line level.
REQ-014 The module SHALL have port sda_i, input, 1 bit: sensed SDA line level.

Function
REQ-015 Acceptance SHALL occur on any cycle with req=1 and ready=1: latch addr/wdata, clear nack, enter START; req while ready=0 is ignored.
REQ-016 The bit period SHALL be four quarters Q0..Q3, each DIVIDER cycles, counted by qcnt (0..DIVIDER-1) plus a 2-bit quarter index; qcnt wraps to 0 and the quarter advances after DIVIDER-1; Q3 wraps to Q0 and advances the bit/state.
REQ-017 FSM states SHALL be IDLE, START, ADDR (8 bits: addr[6:0] MSB first, then R/W=0), AACK (1 bit), DATA (8 bits: wdata MSB first), DACK (1 bit), STOP (1 bit).
REQ-018 In IDLE, counters SHALL be held at 0 and scl_oe=sda_oe=0.
REQ-019 In START, scl_oe SHALL be 0 throughout, sda_oe=0 in Q0-Q1 and sda_oe=1 in Q2-Q3.
REQ-020 In ADDR/AACK/DATA/DACK, scl_oe SHALL be 1 in Q0-Q1 and 0 in Q2-Q3.
REQ-021 SDA SHALL change only at Q1 entry: sda_oe = !bit for data bits, and 0 in AACK/DACK.
REQ-022 At Q3 entry of AACK/DACK, sda_i SHALL be sampled; sda_i=1 sets nack=1.
REQ-023 A NACK in AACK SHALL skip DATA/DACK and go to STOP.
REQ-024 In STOP, scl_oe SHALL be 1 in Q0 and 0 in Q1-Q3; sda_oe SHALL be 1 in Q0-Q1 and 0 in Q2-Q3.
REQ-025 At STOP completion, done SHALL pulse for 1 cycle, the FSM enters IDLE and ready=1 on the next cycle.
REQ-026 An unstretched ACKed transfer SHALL last exactly 20 bit periods = 80*DIVIDER cycles from acceptance to done; a NACKed address SHALL last 11 bit periods = 44*DIVIDER cycles.
REQ-027 Outputs SHALL be registered; no combinational path SHALL exist from inputs to outputs.

Reset
REQ-028 While rst=1, the module SHALL force IDLE, counters=0, ready=1, done=0, nack=0, scl_oe=0, sda_oe=0, regardless of req.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer without a done pulse; the bus is released on the cycle after rst is sampled.

Configuration
REQ-030 With macro I2C_XFER_STRETCH_EN defined, when in Q2 or Q3 of a bit period with scl_oe=0 and scl_i=0, qcnt and the quarter index SHALL hold (clock stretch) until scl_i=1, and outputs SHALL remain unchanged during the hold.
REQ-031 With I2C_XFER_STRETCH_EN undefined, scl_i SHALL be ignored and timing SHALL be fixed per REQ-026.

Verification (DIVIDER=4)
REQ-032 The bench SHALL check: addr=0x50, wdata=0xA5, slave ACKs both -> sda_oe bit sequence 0,1,0,1,1,1,1,1 in ADDR and 0,1,0,1,1,0,1,0 in DATA; done at cycle 320 after acceptance; nack=0.
REQ-033 The bench SHALL check: address NACK (sda_i=1 in AACK) -> no DATA bits; done at cycle 176; nack=1.
REQ-034 The bench SHALL check: req held high during a transfer -> exactly one transfer, with the next acceptance no earlier than the cycle after done.
REQ-035 The bench SHALL check: rst pulsed at cycle 100 of a transfer -> scl_oe=sda_oe=0 and ready=1 on the next cycle, and no done pulse.
REQ-036 The bench SHALL check, with I2C_XFER_STRETCH_EN defined: scl_i held 0 for 10 cycles at Q2 of bit 3 -> done delayed by exactly 10 cycles (cycle 330).
REQ-037 The bench SHALL check, with I2C_XFER_STRETCH_EN undefined: the same stimulus as REQ-036 -> done at cycle 320.

Source files
------------

// File: rtl/i2c_xfer_ctrl.sv
// Single-byte I2C write master: START, 7-bit address + W, ACK, data byte, ACK, STOP.
// Optional clock stretching is compiled in with I2C_XFER_STRETCH_EN.
module i2c_xfer_ctrl #(
  parameter int DIVIDER = 250,
  parameter int CBITS   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic       done,
  output logic       nack,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_i,
  input  logic       sda_i
);

  // IDLE wait req | START sda falls | ADDR 7b+W | AACK | DATA 8b | DACK | STOP sda rises
  typedef enum logic [2:0] {IDLE, START, ADDR, AACK, DATA, DACK, STOP} state_t;

  state_t           state_q, state_d;
  logic [CBITS-1:0] qcnt_q, qcnt_d;
  logic [1:0]       quar_q, quar_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic [6:0]       addr_q;
  logic [7:0]       wdata_q;
  logic             nack_q, nack_d;
  logic             ready_q, done_q, scl_oe_q, sda_oe_q;
  logic             hold, q_wrap, q_step, bit_end, q1_entry, accept, cur_bit;
  logic [7:0]       addr_byte;

`ifdef I2C_XFER_STRETCH_EN
  // A slave holding SCL low while we have released it freezes the bit timer.
  assign hold = quar_q[1] && !scl_oe_q && !scl_i;
`else
  logic unused_scl_i;
  assign unused_scl_i = scl_i;
  assign hold         = 1'b0;
`endif

  assign q_wrap    = (qcnt_q == CBITS'(DIVIDER - 1));
  assign q_step    = (state_q != IDLE) && !hold && q_wrap;
  assign bit_end   = q_step && (quar_q == 2'd3);
  assign q1_entry  = q_step && (quar_q == 2'd0);
  assign accept    = (state_q == IDLE) && req && ready_q;
  assign addr_byte = {addr_q, 1'b0};
  assign cur_bit   = (state_q == ADDR) ? addr_byte[~bcnt_q] : wdata_q[~bcnt_q];

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    quar_d  = quar_q;
    bcnt_d  = bcnt_q;
    nack_d  = nack_q;
    if (state_q == IDLE) begin
      qcnt_d = '0;
      quar_d = '0;
      bcnt_d = '0;
      if (accept) begin
        state_d = START;
        nack_d  = 1'b0;
      end
    end else if (!hold) begin
      if (q_wrap) begin
        qcnt_d = '0;
        quar_d = quar_q + 2'd1;
      end else begin
        qcnt_d = qcnt_q + CBITS'(1);
      end
      if (q_step && (quar_q == 2'd2) && ((state_q == AACK) || (state_q == DACK)) && sda_i)
        nack_d = 1'b1;
      if (bit_end) begin
        case (state_q)
          START: state_d = ADDR;
          ADDR: begin
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) state_d = AACK;
          end
          AACK: state_d = nack_q ? STOP : DATA;
          DATA: begin
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) state_d = DACK;
          end
          DACK:    state_d = STOP;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      qcnt_q   <= '0;
      quar_q   <= '0;
      bcnt_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      nack_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      quar_q  <= quar_d;
      bcnt_q  <= bcnt_d;
      nack_q  <= nack_d;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      ready_q <= (state_d == IDLE);
      done_q  <= bit_end && (state_q == STOP);
      case (state_d)
        ADDR, AACK, DATA, DACK: scl_oe_q <= !quar_d[1];
        STOP:                   scl_oe_q <= (quar_d == 2'd0);
        default:                scl_oe_q <= 1'b0;
      endcase
      // Data SDA only moves at Q1 entry, while SCL is held low.
      case (state_d)
        START:      sda_oe_q <= quar_d[1];
        ADDR, DATA: if (q1_entry) sda_oe_q <= !cur_bit;
        AACK, DACK: if (q1_entry) sda_oe_q <= 1'b0;
        STOP:       sda_oe_q <= !quar_d[1];
        default:    sda_oe_q <= 1'b0;
      endcase
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign nack   = nack_q;
  assign scl_oe = scl_oe_q;
  assign sda_oe = sda_oe_q;

endmodule

// File: tb/tb_i2c_xfer_ctrl.sv
// Bench for i2c_xfer_ctrl at DIVIDER=4: vector table of transfers, SDA bit scoreboard,
// req-held/reset-abort sequence and stretch timing (expectation follows I2C_XFER_STRETCH_EN).
module tb_i2c_xfer_ctrl;
  localparam int DIV = 4;
`ifdef I2C_XFER_STRETCH_EN
  localparam int STRETCH_LAT = 330;
`else
  localparam int STRETCH_LAT = 320;
`endif

  typedef struct {
    logic [6:0] addr;
    logic [7:0] wdata;
    bit         ack_a;
    bit         ack_d;
    int         exp_lat;
    bit         exp_nack;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       ready, done, nack, scl_oe, sda_oe;
  logic       scl_i = 1'b1;
  logic       sda_i;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   exp_q[$];
  bit   mon_en = 1'b0;
  logic scl_prev = 1'b0;
  int   fall_cnt = 0;
  bit   ack_a = 1'b0;
  bit   ack_d = 1'b0;
  vec_t vecs[4];

  i2c_xfer_ctrl #(.DIVIDER(DIV), .CBITS(4)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .nack(nack), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .scl_i(scl_i), .sda_i(sda_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Open-drain SDA: master pull or slave ACK pull during the 9th / 18th SCL low phase.
  assign sda_i = !(sda_oe || (fall_cnt == 9 && ack_a) || (fall_cnt == 18 && ack_d));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_bits(input vec_t v);
    logic [7:0] b;
    b = {v.addr, 1'b0};
    for (int i = 7; i >= 0; i--) exp_q.push_back(!b[i]);
    exp_q.push_back(1'b0);
    if (v.ack_a) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back(!v.wdata[i]);
      exp_q.push_back(1'b0);
    end
    exp_q.push_back(1'b1);
  endtask

  // Every SCL release the master makes carries a scoreboarded SDA level.
  always @(negedge clk) begin
    bit e;
    if (mon_en) begin
      if (scl_oe && !scl_prev) fall_cnt++;
      if (!scl_oe && scl_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_scl_pulse: got sda_oe=%0b expected no pulse (cycle %0d)", sda_oe, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("sda_bit", sda_oe, e);
        end
      end
    end
    scl_prev = scl_oe;
  end

  task automatic run_xfer(input vec_t v, input bit hold_req, input bit stretch,
                          output int acc_edge, output int done_edge);
    int k;
    int early;
    addr     = v.addr;
    wdata    = v.wdata;
    ack_a    = v.ack_a;
    ack_d    = v.ack_d;
    fall_cnt = 0;
    push_bits(v);
    mon_en   = 1'b1;
    chk("ready_before_req", ready, 1);
    req = 1'b1;
    @(negedge clk);
    acc_edge = cyc;
    chk("ready_after_accept", ready, 0);
    if (!hold_req) req = 1'b0;
    addr  = ~v.addr;
    wdata = ~v.wdata;
    done_edge = -1;
    early = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      k = cyc - acc_edge;
      scl_i = !(stretch && k >= 56 && k < 66);
      if (done) begin
        done_edge = cyc;
        break;
      end
      if (ready) early++;
    end
    scl_i = 1'b1;
    if (done_edge < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 1000 cycles");
      done_edge = acc_edge;
    end
    chk("ready_low_during_xfer", early, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a, d, a2, dcount;
    vecs[0] = '{7'h50, 8'hA5, 1'b1, 1'b1, 320, 1'b0};
    vecs[1] = '{7'h50, 8'hA5, 1'b0, 1'b1, 176, 1'b1};
    vecs[2] = '{7'h2B, 8'h3C, 1'b1, 1'b0, 320, 1'b1};
    vecs[3] = '{7'h7F, 8'h00, 1'b1, 1'b1, 320, 1'b0};

    rst = 1'b1;
    req = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_nack", nack, 0);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    rst = 1'b0;
    req = 1'b0;
    @(negedge clk);
    chk("idle_scl_oe", scl_oe, 0);

    for (int i = 0; i < 4; i++) begin
      run_xfer(vecs[i], 1'b0, 1'b0, a, d);
      chk("latency", d - a, vecs[i].exp_lat);
      chk("nack", nack, vecs[i].exp_nack);
      chk("bits_left", exp_q.size(), 0);
      chk("ready_at_done", ready, 1);
      @(negedge clk);
      chk("done_width", done, 0);
      chk("nack_hold", nack, vecs[i].exp_nack);
      repeat (3) @(negedge clk);
    end

    run_xfer(vecs[0], 1'b0, 1'b1, a, d);
    chk("stretch_latency", d - a, STRETCH_LAT);
    chk("stretch_nack", nack, 0);
    chk("stretch_bits_left", exp_q.size(), 0);
    repeat (3) @(negedge clk);

    // req held high: NACKed transfer, then immediate re-acceptance, then abort by reset
    run_xfer(vecs[1], 1'b1, 1'b0, a, d);
    chk("hold_latency", d - a, 176);
    chk("hold_nack", nack, 1);
    chk("hold_ready_at_done", ready, 1);
    addr     = vecs[0].addr;
    wdata    = vecs[0].wdata;
    ack_a    = 1'b1;
    ack_d    = 1'b1;
    fall_cnt = 0;
    push_bits(vecs[0]);
    @(negedge clk);
    a2 = cyc;
    chk("reaccept_ready", ready, 0);
    chk("reaccept_nack_clear", nack, 0);
    req = 1'b0;
    while (cyc < a2 + 99) @(negedge clk);
    chk("scl_low_pre_rst", scl_oe, 1);
    mon_en = 1'b0;
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_scl_oe", scl_oe, 0);
    chk("abort_sda_oe", sda_oe, 0);
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("no_done_after_abort", dcount, 0);
    chk("abort_idle_ready", ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
